memory_access_stage: RTL and testbench

MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

---
 rtl/cpu_types_pkg.sv | 17 +
 rtl/sat_counter.sv | 31 +++
 rtl/memory_access_stage.sv | 171 +++++++++++++++++
 tb/tb_memory_access_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_types_pkg : shared CPU datapath types (word, pipe latch control)  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    PIPE_ENABLE = 2'd0,
    PIPE_STALL  = 2'd1,
    PIPE_NOP    = 2'd2
  } pipe_state_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_counter : up-counter that sticks at all-ones                      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_max = '1;

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_count <= '0;
    end else if (en && (r_count != c_max)) begin
      r_count <= r_count + c_one;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/memory_access_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memory_access_stage : MEM stage data-cache handshake, stall, fault    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module memory_access_stage
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        m_valid,
  input  logic        m_MemRead,
  input  logic        m_MemWrite,
  input  logic        m_halt,
  input  word_t       m_addr,
  input  word_t       m_rdat2,
  input  logic        dhit,
  input  word_t       dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output word_t       dmemaddr,
  output word_t       dmemstore,
  output word_t       m_dmemload,
  output pipe_state_t mw_state,
  output logic        em_stall,
  output logic        m_fault,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic   r_ren;
  logic   r_wen;
  word_t  r_addr;
  word_t  r_data;
  logic   r_fault;

  logic   w_memop;
  logic   w_is_store;
  logic   w_misaligned;
  logic   w_fault_set;
  logic   w_capture;
  logic   w_cnt_en;

  assign w_memop      = m_valid & (m_MemRead | m_MemWrite);
  assign w_is_store   = m_MemWrite;
  assign w_misaligned = |m_addr[1:0];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Request is latched on entry to WAIT so it stays stable however upstream behaves.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_ren  <= 1'b0;
      r_wen  <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else if (w_capture) begin
      r_ren  <= dmemREN;
      r_wen  <= dmemWEN;
      r_addr <= m_addr;
      r_data <= m_rdat2;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_fault <= 1'b0;
    end else if (w_fault_set) begin
      r_fault <= 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    dmemREN      = 1'b0;
    dmemWEN      = 1'b0;
    dmemaddr     = m_addr;
    dmemstore    = m_rdat2;
    m_dmemload   = '0;
    mw_state     = PIPE_ENABLE;
    em_stall     = 1'b0;
    w_fault_set  = 1'b0;
    w_capture    = 1'b0;

    case (r_state)
      IDLE: begin
        if (m_valid && m_halt) begin
          w_next_state = HALTED;
        end else if (w_memop && w_misaligned) begin
          mw_state    = PIPE_NOP;
          w_fault_set = 1'b1;
        end else if (w_memop) begin
          // A simultaneous read+write is treated as a store.
          dmemWEN = w_is_store;
          dmemREN = ~w_is_store;
          if (dhit) begin
            if (!w_is_store) begin
              m_dmemload = dmemload;
            end
          end else begin
            mw_state     = PIPE_STALL;
            em_stall     = 1'b1;
            w_capture    = 1'b1;
            w_next_state = WAIT;
          end
        end
      end

      WAIT: begin
        dmemREN   = r_ren;
        dmemWEN   = r_wen;
        dmemaddr  = r_addr;
        dmemstore = r_data;
        if (dhit) begin
          if (r_ren) begin
            m_dmemload = dmemload;
          end
          w_next_state = IDLE;
        end else begin
          mw_state = PIPE_STALL;
          em_stall = 1'b1;
        end
      end

      HALTED: begin
        mw_state = PIPE_STALL;
        em_stall = 1'b1;
      end

      default: begin
        w_next_state = IDLE;
      end
    endcase

    // Reset kills any outstanding request combinationally, not at the next edge.
    if (!nRST) begin
      dmemREN    = 1'b0;
      dmemWEN    = 1'b0;
      m_dmemload = '0;
    end
  end

  assign w_cnt_en = em_stall & (r_state != HALTED);

  sat_counter #(
    .WIDTH (16)
  ) u_stall_counter (
    .CLK   (CLK),
    .nRST  (nRST),
    .en    (w_cnt_en),
    .count (stall_cnt)
  );

  assign m_fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_memory_access_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_memory_access_stage : directed self-checking bench for MEM stage   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_memory_access_stage;
  import cpu_types_pkg::*;

  logic        CLK;
  logic        nRST;
  logic        m_valid;
  logic        m_MemRead;
  logic        m_MemWrite;
  logic        m_halt;
  logic [31:0] m_addr;
  logic [31:0] m_rdat2;
  logic        dhit;
  logic [31:0] dmemload;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic [31:0] m_dmemload;
  pipe_state_t mw_state;
  logic        em_stall;
  logic        m_fault;
  logic [15:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] c_en  = 32'd0;
  localparam logic [31:0] c_st  = 32'd1;
  localparam logic [31:0] c_nop = 32'd2;

  memory_access_stage dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .m_valid    (m_valid),
    .m_MemRead  (m_MemRead),
    .m_MemWrite (m_MemWrite),
    .m_halt     (m_halt),
    .m_addr     (m_addr),
    .m_rdat2    (m_rdat2),
    .dhit       (dhit),
    .dmemload   (dmemload),
    .dmemREN    (dmemREN),
    .dmemWEN    (dmemWEN),
    .dmemaddr   (dmemaddr),
    .dmemstore  (dmemstore),
    .m_dmemload (m_dmemload),
    .mw_state   (mw_state),
    .em_stall   (em_stall),
    .m_fault    (m_fault),
    .stall_cnt  (stall_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    m_valid    = 1'b0;
    m_MemRead  = 1'b0;
    m_MemWrite = 1'b0;
    m_halt     = 1'b0;
    dhit       = 1'b0;
    dmemload   = 32'h0;
  endtask

  initial begin
    nRST    = 1'b0;
    m_addr  = 32'h0;
    m_rdat2 = 32'h0;
    idle_inputs();

    // Reset state
    #12;
    check("rst_cnt",   {16'h0, stall_cnt}, 32'h0);
    check("rst_fault", {31'h0, m_fault},   32'h0);
    check("rst_ren",   {31'h0, dmemREN},   32'h0);
    #8 nRST = 1'b1;
    cyc();

    // Zero-wait load
    m_valid = 1'b1; m_MemRead = 1'b1; m_addr = 32'h100; dhit = 1'b1; dmemload = 32'hDEADBEEF;
    #2;
    check("ld0_ren",   {31'h0, dmemREN},  32'h1);
    check("ld0_wen",   {31'h0, dmemWEN},  32'h0);
    check("ld0_addr",  dmemaddr,          32'h100);
    check("ld0_state", {30'h0, mw_state}, c_en);
    check("ld0_data",  m_dmemload,        32'hDEADBEEF);
    check("ld0_stall", {31'h0, em_stall}, 32'h0);
    cyc();
    idle_inputs();
    #2;
    check("ld0_cnt",    {16'h0, stall_cnt}, 32'h0);
    check("idle_load0", m_dmemload,         32'h0);
    check("idle_ren",   {31'h0, dmemREN},   32'h0);

    // Store with three wait cycles
    m_valid = 1'b1; m_MemWrite = 1'b1; m_addr = 32'h204; m_rdat2 = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("st_wen",   {31'h0, dmemWEN},  32'h1);
      check("st_addr",  dmemaddr,          32'h204);
      check("st_data",  dmemstore,         32'h12345678);
      check("st_state", {30'h0, mw_state}, c_st);
      check("st_stall", {31'h0, em_stall}, 32'h1);
      cyc();
    end
    dhit = 1'b1;
    #2;
    check("st_done_wen",   {31'h0, dmemWEN},  32'h1);
    check("st_done_state", {30'h0, mw_state}, c_en);
    check("st_done_stall", {31'h0, em_stall}, 32'h0);
    check("st_done_load",  m_dmemload,        32'h0);
    cyc();
    idle_inputs();
    #2;
    check("st_cnt",   {16'h0, stall_cnt}, 32'd3);
    check("st_after", {31'h0, dmemWEN},   32'h0);
    check("st_idle",  {30'h0, mw_state},  c_en);

    // Read and write together behaves as a store
    m_valid = 1'b1; m_MemRead = 1'b1; m_MemWrite = 1'b1; m_addr = 32'h300; dhit = 1'b1; dmemload = 32'h55AA55AA;
    #2;
    check("rw_ren",  {31'h0, dmemREN}, 32'h0);
    check("rw_wen",  {31'h0, dmemWEN}, 32'h1);
    check("rw_load", m_dmemload,       32'h0);
    cyc();
    idle_inputs();

    // Invalid slot suppresses misaligned fault
    m_MemRead = 1'b1; m_addr = 32'h103;
    #2;
    check("inv_state", {30'h0, mw_state}, c_en);
    check("inv_ren",   {31'h0, dmemREN},  32'h0);
    cyc();
    check("inv_fault", {31'h0, m_fault},  32'h0);

    // Misaligned load
    m_valid = 1'b1; m_addr = 32'h102;
    #2;
    check("mis_ren",   {31'h0, dmemREN},  32'h0);
    check("mis_state", {30'h0, mw_state}, c_nop);
    check("mis_stall", {31'h0, em_stall}, 32'h0);
    check("mis_pre",   {31'h0, m_fault},  32'h0);
    cyc();
    check("mis_fault", {31'h0, m_fault},  32'h1);
    dhit = 1'b1;
    for (int i = 0; i < 10; i++) begin
      m_addr = 32'h1000 + 32'(i * 4); dmemload = 32'hA000 + 32'(i);
      #2;
      check("al_load", m_dmemload, 32'hA000 + 32'(i));
      cyc();
    end
    check("mis_sticky", {31'h0, m_fault}, 32'h1);
    idle_inputs();

    // Reset asserted off-edge in the middle of a wait
    m_valid = 1'b1; m_MemRead = 1'b1; m_addr = 32'h400;
    cyc();
    #2;
    check("w_ren",   {31'h0, dmemREN},  32'h1);
    check("w_state", {30'h0, mw_state}, c_st);
    nRST = 1'b0;
    #1;
    check("ar_ren",   {31'h0, dmemREN},   32'h0);
    check("ar_cnt",   {16'h0, stall_cnt}, 32'h0);
    check("ar_fault", {31'h0, m_fault},   32'h0);
    idle_inputs();
    #3 nRST = 1'b1;
    cyc();
    #2;
    check("ar_idle_state", {30'h0, mw_state}, c_en);
    check("ar_idle_stall", {31'h0, em_stall}, 32'h0);
    check("ar_idle_ren",   {31'h0, dmemREN},  32'h0);

    // Long wait saturates the stall counter
    m_valid = 1'b1; m_MemRead = 1'b1; m_addr = 32'h800;
    repeat (65534) cyc();
    check("sat_fffe", {16'h0, stall_cnt}, 32'hFFFE);
    repeat (70000 - 65534) cyc();
    check("sat_ffff",  {16'h0, stall_cnt}, 32'hFFFF);
    check("sat_stall", {31'h0, em_stall},  32'h1);
    dhit = 1'b1; dmemload = 32'hCAFE0001;
    #2;
    check("sat_load", m_dmemload, 32'hCAFE0001);
    cyc();
    idle_inputs();
    check("sat_hold", {16'h0, stall_cnt}, 32'hFFFF);

    // Halt: clear counter first so HALTED cycles would be visible if counted
    #2 nRST = 1'b0;
    #2 nRST = 1'b1;
    cyc();
    m_valid = 1'b1; m_halt = 1'b1;
    #2;
    check("h_state", {30'h0, mw_state}, c_en);
    check("h_stall", {31'h0, em_stall}, 32'h0);
    cyc();
    m_halt = 1'b0; m_MemRead = 1'b1; m_addr = 32'h10; dhit = 1'b1; dmemload = 32'h77;
    #2;
    check("hd_ren",   {31'h0, dmemREN},  32'h0);
    check("hd_state", {30'h0, mw_state}, c_st);
    check("hd_stall", {31'h0, em_stall}, 32'h1);
    check("hd_load",  m_dmemload,        32'h0);
    repeat (5) cyc();
    check("hd_ren2",   {31'h0, dmemREN},   32'h0);
    check("hd_stall2", {31'h0, em_stall},  32'h1);
    check("hd_cnt",    {16'h0, stall_cnt}, 32'h0);
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
